// File: rtl/rotr_undo_seq.sv
// rotr_undo_seq: restores a rotate-right word by rotating left one bit per clock
module rotr_undo_seq #(
    parameter int WIDTH = 4,
    parameter int SEL_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] shifted_q,
    input  logic [SEL_W-1:0] sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
    state_t state, state_n;
    logic [SEL_W-1:0] cnt;
    logic [WIDTH-1:0] data_reg;
    always_comb begin
        state_n = state;
        in_ready = state == IDLE;
        out_valid = state == HOLD;
        busy = state != IDLE;
        q = data_reg;
        state_n = (state == IDLE)  ? (in_valid ? ((sel == '0) ? HOLD : SHIFT) : IDLE) :
                  (state == SHIFT) ? ((cnt == SEL_W'(1)) ? HOLD : SHIFT) :
                  (out_ready ? IDLE : HOLD);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            data_reg <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && in_valid) begin
                data_reg <= shifted_q;
                cnt <= sel;
            end else if (state == SHIFT) begin
                data_reg <= {data_reg[WIDTH-2:0], data_reg[WIDTH-1]};
                cnt <= cnt - SEL_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_rotr_undo_seq.sv
// tb_rotr_undo_seq: directed and random checks of rotr_undo_seq against a rotate-left scoreboard
module tb_rotr_undo_seq;
    logic       clk = 0;
    logic       rst_n = 0;
    logic       in_valid = 0;
    logic       in_ready;
    logic [3:0] shifted_q = 0;
    logic [1:0] sel = 0;
    logic       out_valid;
    logic       out_ready = 0;
    logic [3:0] q;
    logic       busy;
    int tests = 0;
    int fails = 0;
    logic [3:0] exp_q[$];

    rotr_undo_seq #(.WIDTH(4), .SEL_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .shifted_q(shifted_q), .sel(sel), .out_valid(out_valid),
        .out_ready(out_ready), .q(q), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] rotl(input logic [3:0] d, input int s);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[(i + s) % 4] = d[i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge after the output transfer.
    task automatic xfer(input logic [3:0] d, input logic [1:0] s, input int lat,
                        input int hold, input bit rnd);
        int n;
        bit go;
        logic [3:0] e;
        chk("idle_in_ready", in_ready, 1);
        in_valid = 1;
        shifted_q = d;
        sel = s;
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        exp_q.push_back(rotl(d, s));
        @(negedge clk);
        n = 1;
        // Keep offering junk while busy: it must be ignored and not disturb the held word.
        shifted_q = 4'($urandom);
        sel = 2'($urandom);
        while (!out_valid && n < 20) begin
            chk("busy_in_ready", in_ready, 0);
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        chk("latency", n, lat);
        e = exp_q.pop_front();
        for (int c = 0; c < 50; c++) begin
            chk("out_valid", out_valid, 1);
            chk("q", q, e);
            chk("hold_in_ready", in_ready, 0);
            go = rnd ? (c == 49 || $urandom_range(0, 1) == 1) : (c >= hold);
            out_ready = go;
            @(negedge clk);
            if (go) break;
        end
        in_valid = 0;
        out_ready = 0;
        chk("after_out_valid", out_valid, 0);
        chk("after_busy", busy, 0);
    endtask

    initial begin
        in_valid = 1;
        shifted_q = 4'b1111;
        sel = 2'd2;
        repeat (3) begin
            @(negedge clk);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_q", q, 4'b0000);
        end
        rst_n = 1;
        in_valid = 0;
        @(negedge clk);
        chk("rel_in_ready", in_ready, 1);
        chk("rel_out_valid", out_valid, 0);

        xfer(4'b1011, 2'd0, 1, 0, 0);
        xfer(4'b1101, 2'd1, 2, 0, 0);
        xfer(4'b1110, 2'd2, 3, 0, 0);
        xfer(4'b0111, 2'd3, 4, 0, 0);
        xfer(4'b0110, 2'd2, 3, 5, 0);

        // Reset on the second SHIFT cycle must abort without producing an output.
        in_valid = 1;
        shifted_q = 4'b0101;
        sel = 2'd3;
        @(negedge clk);
        in_valid = 0;
        chk("mid_busy", busy, 1);
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        repeat (4) begin
            @(negedge clk);
            chk("mid_rst_quiet", out_valid, 0);
        end
        xfer(4'b1000, 2'd1, 2, 0, 0);

        for (int t = 0; t < 200; t++) begin
            logic [3:0] d;
            logic [1:0] s;
            d = 4'($urandom);
            s = 2'($urandom);
            xfer(d, s, int'(s) + 1, 0, 1);
        end
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rotr_undo_seq.md
Name: rotr_undo_seq

Overview:
- Sequential inverse of the team's combinational rotate-right stage: accepts a word rotated right by `sel` positions and restores the original word.
- Restoration is an iterative rotate-left, one bit position per clock.
- Valid/ready handshakes on both input and output.
- Sits directly downstream of the rotate-right stage on the datapath. It lets the verification bench, and later the dual-port RAM read path, recover pre-rotation data without a wide combinational barrel.

Parameters:
- WIDTH, 4, data width in bits; must be a power of 2, at least 2.
- SEL_W, 2, width of the rotate amount; equals log2(WIDTH).

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  reset, synchronous and active-low; sampled on the clk rising edge.
- in_valid  input  1  upstream has a rotated word plus rotate amount.
- in_ready  output  1  block can accept a new word this cycle.
- shifted_q  input  WIDTH  rotated data, as produced by the rotate-right stage.
- sel  input  SEL_W  rotate-right amount that was applied (0..WIDTH-1).
- out_valid  output  1  restored word is available.
- out_ready  input  1  downstream accepts the restored word.
- q  output  WIDTH  restored (un-rotated) data.
- busy  output  1  high whenever the block is not in IDLE.

Behaviour:
- Reset (rst_n low at an edge):
  - State goes to IDLE, cnt to 0, q to 0, out_valid to 0, busy to 0.
  - in_ready reads 1 in the first cycle after reset is released.
  - Any in-flight transaction is discarded.
- State machine: IDLE, SHIFT, HOLD.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On an edge with in_valid & in_ready: data_reg <= shifted_q and cnt <= sel.
  - If sel == 0, next state is HOLD; otherwise next state is SHIFT.
- SHIFT:
  - in_ready = 0.
  - Each edge: data_reg <= {data_reg[WIDTH-2:0], data_reg[WIDTH-1]} (rotate left by 1) and cnt <= cnt - 1.
  - When the pre-decrement cnt == 1, next state is HOLD.
- HOLD:
  - out_valid = 1, q = data_reg, in_ready = 0.
  - q and out_valid stay stable until an edge with out_ready = 1; then the state returns to IDLE.
- Latency from the accept edge to out_valid high:
  - sel == 0: 1 cycle.
  - sel == k (k > 0): k + 1 cycles.
- Throughput and backpressure:
  - No overlap: the next accept can occur no earlier than the cycle after HOLD completes.
  - in_valid while busy is ignored. Upstream must hold in_valid, data and sel until in_ready.
  - Input data and sel are sampled only on the accept edge; later changes have no effect.
- out_ready asserted outside HOLD has no effect.
- q output:
  - Registered from data_reg.
  - Value outside HOLD is don't-care for checking, but must be X-free after reset.
- Arithmetic:
  - cnt is SEL_W bits wide and never underflows. SHIFT is entered only with cnt >= 1.
  - The rotate amount is interpreted modulo WIDTH.
- Boundary cases:
  - sel = WIDTH-1 gives the maximum latency of WIDTH cycles.
  - Output must equal the original word for every (data, sel) pair.
- Reset mid-operation: rst_n low in SHIFT or HOLD returns the block to IDLE at that edge, with out_valid = 0 on the following cycle and no output produced.

Test Plan:
- Reset check: hold rst_n = 0 for 3 cycles with in_valid = 1 -> out_valid = 0, busy = 0, q = 4'b0000 throughout; in_ready = 1 on the first cycle after release.
- sel = 0: send shifted_q = 4'b1011 with out_ready = 1 -> out_valid high 1 cycle after accept, q = 4'b1011, then back in IDLE.
- Each nonzero sel restores 4'b1011, with out_ready = 1:
  - shifted_q = 4'b1101, sel = 1 -> latency 2.
  - shifted_q = 4'b1110, sel = 2 -> latency 3.
  - shifted_q = 4'b0111, sel = 3 -> latency 4.
- Backpressure: sel = 2, shifted_q = 4'b0110, out_ready = 0 for 5 cycles -> out_valid and q = 4'b1001 stay stable, in_ready = 0 throughout; release out_ready -> one transfer, then IDLE.
- Mid-operation reset: accept sel = 3, assert rst_n = 0 on the second SHIFT cycle -> next cycle IDLE, out_valid never asserted; a following sel = 1, shifted_q = 4'b1000 transaction yields q = 4'b0001.
- Random loop: 200 transactions with random data, random sel and random out_ready -> each q equals the rotate-left of shifted_q by sel; no lost or duplicated outputs.
